// File: rtl/pipe_stall_unit.sv
// rtl/pipe_stall_unit.sv - Pipeline stall/flush responder owning IF/ID and ID/EX control registers.
// Applies freeze > flush > load-use bubble > normal advance each cycle.
module pipe_stall_unit #(
  parameter int DW    = 32,
  parameter int CTRLW = 9,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_use_req,
  input  logic             branch_taken,
  input  logic             busy_req,
  input  logic [DW-1:0]    if_pc4,
  input  logic [DW-1:0]    if_instr,
  input  logic [CTRLW-1:0] id_ctrl,
  output logic             pc_we,
  output logic [DW-1:0]    ifid_pc4,
  output logic [DW-1:0]    ifid_instr,
  output logic [CTRLW-1:0] idex_ctrl,
  output logic [CNTW-1:0]  stall_cycles,
  output logic [CNTW-1:0]  flush_count
);

  typedef enum logic [1:0] {RUN, LU_HOLD, FREEZE} state_t;
  typedef enum logic [1:0] {ACT_NORMAL, ACT_FREEZE, ACT_FLUSH, ACT_BUBBLE} act_t;

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  state_t state, state_nxt;
  act_t   act;

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // LU_HOLD suppresses a second bubble for a load-use request that is still held high
  always_comb begin
    state_nxt = RUN;
    act       = ACT_NORMAL;
    pc_we     = 1'b1;
    if (rst) begin
      pc_we = 1'b0;
    end else if (busy_req) begin
      act       = ACT_FREEZE;
      pc_we     = 1'b0;
      state_nxt = FREEZE;
    end else if (branch_taken) begin
      act = ACT_FLUSH;
    end else if (load_use_req && state != LU_HOLD) begin
      act       = ACT_BUBBLE;
      pc_we     = 1'b0;
      state_nxt = LU_HOLD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_pc4     <= '0;
      ifid_instr   <= '0;
      idex_ctrl    <= '0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      case (act)
        ACT_FREEZE: ;
        ACT_FLUSH: begin
          ifid_pc4   <= '0;
          ifid_instr <= '0;
          idex_ctrl  <= '0;
          if (flush_count != CNT_MAX) flush_count <= flush_count + 1'b1;
        end
        ACT_BUBBLE: begin
          idex_ctrl <= '0;
          if (stall_cycles != CNT_MAX) stall_cycles <= stall_cycles + 1'b1;
        end
        default: begin
          ifid_pc4   <= if_pc4;
          ifid_instr <= if_instr;
          idex_ctrl  <= id_ctrl;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stall_unit.sv
// tb/tb_pipe_stall_unit.sv - Self-checking bench for pipe_stall_unit (16-bit and 2-bit counter instances).
module tb_pipe_stall_unit;

  logic        clk = 1'b0;
  logic        rst, load_use_req, branch_taken, busy_req;
  logic [31:0] if_pc4, if_instr;
  logic [8:0]  id_ctrl;

  logic        pc_we, pc_we2;
  logic [31:0] ifid_pc4, ifid_instr, ifid_pc4_2, ifid_instr_2;
  logic [8:0]  idex_ctrl, idex_ctrl2;
  logic [15:0] stall_cycles, flush_count;
  logic [1:0]  stall_cycles2, flush_count2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_stall_unit #(.DW(32), .CTRLW(9), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .load_use_req(load_use_req), .branch_taken(branch_taken),
    .busy_req(busy_req), .if_pc4(if_pc4), .if_instr(if_instr), .id_ctrl(id_ctrl),
    .pc_we(pc_we), .ifid_pc4(ifid_pc4), .ifid_instr(ifid_instr), .idex_ctrl(idex_ctrl),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  pipe_stall_unit #(.DW(32), .CTRLW(9), .CNTW(2)) dut2 (
    .clk(clk), .rst(rst), .load_use_req(load_use_req), .branch_taken(branch_taken),
    .busy_req(busy_req), .if_pc4(if_pc4), .if_instr(if_instr), .id_ctrl(id_ctrl),
    .pc_we(pc_we2), .ifid_pc4(ifid_pc4_2), .ifid_instr(ifid_instr_2), .idex_ctrl(idex_ctrl2),
    .stall_cycles(stall_cycles2), .flush_count(flush_count2)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: unbounded event counts clipped on compare, and a flag recording
  // whether the previous edge already issued a load-use bubble.
  logic [31:0] m_pc4 = '0, m_instr = '0;
  logic [8:0]  m_ctrl = '0;
  int          m_stall = 0, m_flush = 0;
  bit          m_bubbled_last = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_pc4 = '0; m_instr = '0; m_ctrl = '0; m_stall = 0; m_flush = 0; m_bubbled_last = 1'b0;
    end else if (busy_req) begin
      m_bubbled_last = 1'b0;
    end else if (branch_taken) begin
      m_pc4 = '0; m_instr = '0; m_ctrl = '0; m_flush++; m_bubbled_last = 1'b0;
    end else if (load_use_req && !m_bubbled_last) begin
      m_ctrl = '0; m_stall++; m_bubbled_last = 1'b1;
    end else begin
      m_pc4 = if_pc4; m_instr = if_instr; m_ctrl = id_ctrl; m_bubbled_last = 1'b0;
    end
  end

  function automatic int clip(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  always @(negedge clk) begin
    logic exp_we;
    exp_we = !rst && !busy_req && (branch_taken || !(load_use_req && !m_bubbled_last));
    chk("pc_we", 64'(pc_we), 64'(exp_we));
    chk("pc_we_c2", 64'(pc_we2), 64'(exp_we));
    chk("ifid_pc4", 64'(ifid_pc4), 64'(m_pc4));
    chk("ifid_instr", 64'(ifid_instr), 64'(m_instr));
    chk("idex_ctrl", 64'(idex_ctrl), 64'(m_ctrl));
    chk("stall_cycles", 64'(stall_cycles), 64'(clip(m_stall, 65535)));
    chk("flush_count", 64'(flush_count), 64'(clip(m_flush, 65535)));
    chk("stall_cycles_c2", 64'(stall_cycles2), 64'(clip(m_stall, 3)));
    chk("flush_count_c2", 64'(flush_count2), 64'(clip(m_flush, 3)));
  end

  task automatic step(input logic r, input logic lu, input logic br, input logic bz,
                      input logic [31:0] p, input logic [31:0] i, input logic [8:0] c);
    @(posedge clk);
    #1;
    rst = r; load_use_req = lu; branch_taken = br; busy_req = bz;
    if_pc4 = p; if_instr = i; id_ctrl = c;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; load_use_req = 1'b1; branch_taken = 1'b1; busy_req = 1'b1;
    if_pc4 = 32'hDEAD; if_instr = 32'hBEEF; id_ctrl = 9'h1FF;
    @(negedge clk);
    chk("lit_rst_pc_we", 64'(pc_we), 64'd0);
    chk("lit_rst_ifid_instr", 64'(ifid_instr), 64'd0);
    chk("lit_rst_idex_ctrl", 64'(idex_ctrl), 64'd0);

    step(0, 0, 0, 0, 32'h04, 32'h8C080004, 9'h1E3);
    chk("lit_norm_pc_we", 64'(pc_we), 64'd1);
    step(0, 0, 0, 0, 32'h08, 32'h00851020, 9'h0C2);
    chk("lit_norm_instr", 64'(ifid_instr), 64'h8C080004);
    chk("lit_norm_pc4", 64'(ifid_pc4), 64'h04);
    chk("lit_norm_ctrl", 64'(idex_ctrl), 64'h1E3);

    // load-use held two cycles
    step(0, 1, 0, 0, 32'h0C, 32'h00A63020, 9'h0C2);
    chk("lit_lu1_pc_we", 64'(pc_we), 64'd0);
    step(0, 1, 0, 0, 32'h0C, 32'h00A63020, 9'h0C2);
    chk("lit_lu2_pc_we", 64'(pc_we), 64'd1);
    chk("lit_lu_bubble", 64'(idex_ctrl), 64'd0);
    chk("lit_lu_hold_instr", 64'(ifid_instr), 64'h00851020);
    chk("lit_lu_stall", 64'(stall_cycles), 64'd1);
    step(0, 0, 0, 0, 32'h0C, 32'h00A63020, 9'h0C2);
    chk("lit_lu_after_ctrl", 64'(idex_ctrl), 64'h0C2);
    chk("lit_lu_after_instr", 64'(ifid_instr), 64'h00A63020);

    // flush beats load-use
    step(0, 1, 1, 0, 32'h10, 32'h11111111, 9'h1FF);
    chk("lit_fl_pc_we", 64'(pc_we), 64'd1);
    step(0, 0, 0, 0, 32'h40, 32'h22222222, 9'h0A1);
    chk("lit_fl_instr", 64'(ifid_instr), 64'd0);
    chk("lit_fl_ctrl", 64'(idex_ctrl), 64'd0);
    chk("lit_fl_count", 64'(flush_count), 64'd1);
    chk("lit_fl_stall", 64'(stall_cycles), 64'd1);

    // freeze with branch_taken for three cycles
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1, 1, 32'h80, 32'h33333333, 9'h155);
      chk("lit_frz_pc_we", 64'(pc_we), 64'd0);
    end
    chk("lit_frz_instr", 64'(ifid_instr), 64'h22222222);
    chk("lit_frz_flush", 64'(flush_count), 64'd1);
    step(0, 0, 0, 0, 32'h84, 32'h44444444, 9'h0F0);
    chk("lit_unfrz_pc_we", 64'(pc_we), 64'd1);
    step(0, 0, 0, 0, 32'h88, 32'h44444444, 9'h0F0);
    chk("lit_unfrz_instr", 64'(ifid_instr), 64'h44444444);

    // reset while in LU_HOLD
    step(0, 1, 0, 0, 32'h90, 32'h66666666, 9'h033);
    step(1, 1, 0, 0, 32'h90, 32'h66666666, 9'h033);
    step(0, 1, 0, 0, 32'h90, 32'h66666666, 9'h033);
    chk("lit_rstlu_pc_we", 64'(pc_we), 64'd0);
    chk("lit_rstlu_stall", 64'(stall_cycles), 64'd0);
    step(0, 0, 0, 0, 32'h94, 32'h77777777, 9'h033);
    chk("lit_rstlu_stall2", 64'(stall_cycles), 64'd1);

    // reset while in FREEZE
    step(0, 0, 0, 1, 32'hA0, 32'h88888888, 9'h011);
    step(1, 0, 0, 1, 32'hA0, 32'h88888888, 9'h011);
    step(0, 0, 0, 0, 32'h100, 32'h55, 9'h011);
    chk("lit_rstfz_instr", 64'(ifid_instr), 64'd0);
    chk("lit_rstfz_pc_we", 64'(pc_we), 64'd1);
    step(0, 0, 0, 0, 32'h104, 32'h56, 9'h012);
    chk("lit_rstfz_instr2", 64'(ifid_instr), 64'h55);

    // five flushes: 2-bit counter saturates at 3
    for (int k = 0; k < 5; k++) step(0, 0, 1, 0, 32'h200, 32'h99, 9'h0AA);
    step(0, 0, 0, 0, 32'h204, 32'h9A, 9'h0AB);
    chk("lit_sat_flush16", 64'(flush_count), 64'd5);
    chk("lit_sat_flush2", 64'(flush_count2), 64'd3);
    step(0, 0, 0, 0, 32'h208, 32'h9B, 9'h0AC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
